// File: rtl/clock_gerador_pkg.sv
// Shared definitions for the clock divider / tick generator.
`timescale 1ns/1ps

package clock_gerador_pkg;

    // Default width of the half-period counter and of half_period.
    localparam int CNT_W_DEFAULT = 16;

    // Single-step sequencer states:
    //   ST_IDLE : no step in progress
    //   ST_LEAD : step accepted, counting the low lead-in before the rise
    //   ST_BODY : the stepped high phase has started; ends after its low phase
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LEAD = 2'd1,
        ST_BODY = 2'd2
    } step_state_t;

    // A half-period of zero would never complete; it is treated as one.
    function automatic logic [31:0] clamp_half(input logic [31:0] x);
        return (x == 32'd0) ? 32'd1 : x;
    endfunction

endpackage

// File: rtl/clock_gerador_edge.sv
// Rising-edge detector for a level input that is already synchronous to clk.
`timescale 1ns/1ps

module clock_gerador_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic din_q;

    // Registered copy of the input, used to spot its 0->1 transition.
    // NOTE: asynchronous reset goes in the sensitivity list; every register
    // that has a defined reset value is cleared in the reset branch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din;
        end
    end

    assign rise = din & ~din_q;

endmodule

// File: rtl/clock_gerador.sv
// Programmable clock divider with rising-edge strobe, run/pause and
// single-step control. saida has a half-period of h_reg clk cycles; h_reg
// only changes on a saida toggle so a phase in progress is never altered.
`timescale 1ns/1ps

module clock_gerador
    import clock_gerador_pkg::*;
#(
    parameter int CNT_W        = CNT_W_DEFAULT,
    parameter int DEFAULT_HALF = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] half_period,
    input  logic             step,
    output logic             saida,
    output logic             borda
);

    // Half-period loaded at reset; zero is promoted to one. CNT_W <= 32.
    localparam logic [CNT_W-1:0] H_RESET = CNT_W'(clamp_half(32'(DEFAULT_HALF)));

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] h_reg;
    logic [CNT_W-1:0] h_next;

    step_state_t state;
    step_state_t state_next;

    logic step_rise;
    logic step_req;
    logic stepping;
    logic step_end;
    logic run;
    logic last;
    logic toggle;

    clock_gerador_edge u_step_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (step),
        .rise (step_rise)
    );

    assign h_next = CNT_W'(clamp_half(32'(half_period)));

    // A step is accepted only when fully idle: not running, saida low and
    // no step already in flight. Anything else is dropped, not queued.
    assign step_req = step_rise & ~en & ~saida & ~stepping;

    // A high phase always completes, so saida itself keeps the counter going.
    assign run  = en | stepping | saida;
    assign last = (cnt == h_reg - CNT_W'(1));

    // At the end of a stepped period the low phase completes without a
    // new rise, unless en came up meanwhile and free-running takes over.
    assign toggle = run & last & ~(step_end & ~en);

    // Step sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Step sequencer next-state logic.
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (step_req)           state_next = ST_LEAD;
            ST_LEAD: if (last && !saida)     state_next = ST_BODY;
            ST_BODY: if (step_end)           state_next = ST_IDLE;
            default:                         state_next = ST_IDLE;
        endcase
    end

    // Step sequencer outputs.
    always_comb begin
        stepping = (state != ST_IDLE);
        step_end = (state == ST_BODY) && !saida && last;
    end

    // Half-period counter, divided clock, reload register and edge strobe.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            saida <= 1'b0;
            h_reg <= H_RESET;
            borda <= 1'b0;
        end else begin
            borda <= toggle & ~saida;
            if (step_req) begin
                cnt <= '0;
            end else if (run) begin
                if (last) begin
                    cnt <= '0;
                    if (toggle) begin
                        saida <= ~saida;
                        h_reg <= h_next;
                    end
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_clock_gerador.sv
// Self-checking bench for clock_gerador: constant vector table, hand
// sequences for pause/step/async reset, and randomized stimulus against a
// phase-level reference model.
`timescale 1ns/1ps

module tb_clock_gerador;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [15:0] half_period = 16'd0;
    logic        step = 1'b0;
    logic        saida1, borda1, saida3, borda3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clock_gerador #(.CNT_W(16), .DEFAULT_HALF(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .half_period(half_period),
        .step(step), .saida(saida1), .borda(borda1)
    );

    clock_gerador #(.CNT_W(16), .DEFAULT_HALF(3)) dut3 (
        .clk(clk), .rst(rst), .en(en), .half_period(half_period),
        .step(step), .saida(saida3), .borda(borda3)
    );

    // Reference model: level of the output, clk edges left in the current
    // phase, the half-period that phase uses, and step bookkeeping.
    typedef struct {
        bit level;
        bit borda;
        int left;
        int h;
        bit stepping;
        bit seen_high;
        bit prev_step;
    } model_t;

    model_t m1, m3;

    function automatic model_t model_reset(input int dflt);
        model_t m;
        m.level     = 1'b0;
        m.borda     = 1'b0;
        m.h         = (dflt < 1) ? 1 : dflt;
        m.left      = m.h;
        m.stepping  = 1'b0;
        m.seen_high = 1'b0;
        m.prev_step = 1'b0;
        return m;
    endfunction

    function automatic model_t model_flip(input model_t m, input logic [15:0] hp);
        model_t n = m;
        n.level = !m.level;
        n.borda = n.level;
        n.h     = (hp == 16'd0) ? 1 : int'(hp);
        n.left  = n.h;
        if (n.level && m.stepping) n.seen_high = 1'b1;
        return n;
    endfunction

    function automatic model_t model_edge(input model_t m, input logic e,
                                          input logic [15:0] hp, input logic s);
        model_t n = m;
        n.borda = 1'b0;
        if (!e && !m.level && !m.stepping && s && !m.prev_step) begin
            n.stepping  = 1'b1;
            n.seen_high = 1'b0;
            n.left      = m.h;
        end else if (e || m.stepping || m.level) begin
            if (m.left > 1) begin
                n.left = m.left - 1;
            end else if (m.stepping && m.seen_high && !m.level) begin
                n.stepping = 1'b0;
                if (e) n = model_flip(n, hp);
                else   n.left = m.h;
            end else begin
                n = model_flip(n, hp);
            end
        end
        n.prev_step = s;
        return n;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs, advance one clk edge, update models, sample 1 ns later.
    task automatic tick(input logic e, input logic [15:0] hp, input logic s);
        en          = e;
        half_period = hp;
        step        = s;
        @(posedge clk);
        m1 = model_edge(m1, e, hp, s);
        m3 = model_edge(m3, e, hp, s);
        #1;
    endtask

    task automatic compare_models(input string tag);
        check({tag, "_saida1"}, int'(saida1), int'(m1.level));
        check({tag, "_borda1"}, int'(borda1), int'(m1.borda));
        check({tag, "_saida3"}, int'(saida3), int'(m3.level));
        check({tag, "_borda3"}, int'(borda3), int'(m3.borda));
    endtask

    task automatic do_reset(input logic e, input logic [15:0] hp);
        rst         = 1'b1;
        en          = e;
        half_period = hp;
        step        = 1'b0;
        m1 = model_reset(1);
        m3 = model_reset(3);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_saida1", int'(saida1), 0);
            check("rst_borda1", int'(borda1), 0);
            check("rst_saida3", int'(saida3), 0);
            check("rst_borda3", int'(borda3), 0);
        end
        rst = 1'b0;
    endtask

    task automatic run_until_rise(input logic [15:0] hp, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            tick(1'b1, hp, 1'b0);
            if (saida1 && borda1) ok = 1'b1;
        end
    endtask

    typedef struct {
        logic        en;
        logic [15:0] hp;
        logic        s1, b1, s3, b3;
    } vec_t;

    vec_t vecs[22];

    initial begin
        string s1_pat, b1_pat, s3_pat, b3_pat;
        bit ok;
        int high_cnt, borda_cnt, rise1, rise3;

        // Expected waveforms after reset, edge 1..22, en=1, half_period=3
        // for edges 1..9 and 5 from edge 10 on. dut1 starts with h=1,
        // dut3 with h=3.
        s1_pat = "1110001110000011111000";
        b1_pat = "1000001000000010000000";
        s3_pat = "0011100011100000111110";
        b3_pat = "0010000010000000100000";
        for (int i = 0; i < 22; i++) begin
            vecs[i].en = 1'b1;
            vecs[i].hp = (i < 9) ? 16'd3 : 16'd5;
            vecs[i].s1 = (s1_pat[i] == "1");
            vecs[i].b1 = (b1_pat[i] == "1");
            vecs[i].s3 = (s3_pat[i] == "1");
            vecs[i].b3 = (b3_pat[i] == "1");
        end

        // Default half-period of 1 with half_period=0: toggle every clk.
        do_reset(1'b1, 16'd0);
        for (int i = 1; i <= 6; i++) begin
            tick(1'b1, 16'd0, 1'b0);
            check("div2_saida", int'(saida1), i % 2);
            check("div2_borda", int'(borda1), i % 2);
        end

        // Divide by 6 and mid-phase half-period change, from the table.
        do_reset(1'b1, 16'd3);
        for (int i = 0; i < 22; i++) begin
            tick(vecs[i].en, vecs[i].hp, 1'b0);
            check($sformatf("vec%0d_saida1", i + 1), int'(saida1), int'(vecs[i].s1));
            check($sformatf("vec%0d_borda1", i + 1), int'(borda1), int'(vecs[i].b1));
            check($sformatf("vec%0d_saida3", i + 1), int'(saida3), int'(vecs[i].s3));
            check($sformatf("vec%0d_borda3", i + 1), int'(borda3), int'(vecs[i].b3));
        end

        // Pause: drop en right after a rise with H=3; the high phase
        // finishes (3 cycles total) and the output then stays low.
        run_until_rise(16'd3, ok);
        check("pause_reach_rise", int'(ok), 1);
        high_cnt  = 1;
        borda_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1'b0, 16'd3, 1'b0);
            high_cnt  += int'(saida1);
            borda_cnt += int'(borda1);
            compare_models("pause");
        end
        check("pause_high_cycles", high_cnt, 3);
        check("pause_borda_count", borda_cnt, 0);
        check("pause_final_saida", int'(saida1), 0);

        // Single step with H=2: step high for 4 edges, low, then a second
        // request inside the stepped period which must be ignored.
        high_cnt  = 0;
        borda_cnt = 0;
        for (int i = 1; i <= 30; i++) begin
            tick(1'b0, 16'd2, (i <= 4) || (i == 6) || (i == 7));
            high_cnt  += int'(saida1);
            borda_cnt += int'(borda1);
            compare_models("step");
        end
        check("step_high_cycles", high_cnt, 2);
        check("step_borda_count", borda_cnt, 1);
        check("step_final_saida", int'(saida1), 0);

        // Asynchronous reset while saida is high.
        run_until_rise(16'd3, ok);
        check("areset_reach_rise", int'(ok), 1);
        #2;
        rst = 1'b1;
        m1 = model_reset(1);
        m3 = model_reset(3);
        #1;
        check("areset_saida1_now", int'(saida1), 0);
        check("areset_borda1_now", int'(borda1), 0);
        repeat (2) @(posedge clk);
        #1;
        check("areset_saida1_held", int'(saida1), 0);
        check("areset_saida3_held", int'(saida3), 0);
        #2;
        rst   = 1'b0;
        rise1 = 0;
        rise3 = 0;
        for (int k = 1; k <= 10; k++) begin
            tick(1'b1, 16'd3, 1'b0);
            if (rise1 == 0 && borda1) rise1 = k;
            if (rise3 == 0 && borda3) rise3 = k;
        end
        check("areset_first_rise_h3", rise3, 3);
        check("areset_first_rise_h1", rise1, 1);

        // Randomized run/pause/step/half-period traffic against the model.
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 3) != 0,
                 16'($urandom_range(0, 4)),
                 $urandom_range(0, 2) == 0);
            compare_models("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/clock_gerador.md
Name: clock_gerador

Overview:
Programmable clock divider and tick generator for the MIPS processor datapath. Derives the slow processor clock `saida` from the board clock `clk`. Also provides a single-cycle rising-edge strobe `borda`, plus run/pause and single-step control for debug. Sits at the top level, between the board oscillator and the processor/monitor logic.

Parameters:
CNT_W, 16, width of the half-period counter and of the half_period input.
DEFAULT_HALF, 1, half-period in clk cycles loaded at reset; a value of 0 is treated as 1.

Ports:
clk  input  1  board clock; all logic is on its rising edge.
rst  input  1  asynchronous, active-high reset.
en  input  1  run enable; 1 = free-running, 0 = pause/step mode.
half_period  input  CNT_W  requested half-period in clk cycles; 0 is treated as 1.
step  input  1  single-step request, level input; only its 0->1 transition counts.
saida  output  1  divided clock, registered, 50% duty.
borda  output  1  one-clk pulse in the cycle saida goes 0->1.

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-high. No internal synchronisers on en/step/half_period; they are synchronous to clk.
- Reset values:
  - saida=0, borda=0, cnt=0.
  - h_reg=max(DEFAULT_HALF,1).
  - step_q=0, stepping=0.
- Half-period register h_reg:
  - Reloads with max(half_period,1) only on a toggle edge of saida.
  - A change of half_period mid-phase never shortens or stretches the current phase.
- Running condition: run = en | stepping | saida.
  - Pausing therefore only takes effect once saida is low; a high phase always completes.
- Counting, on each clk while run=1:
  - If cnt==h_reg-1: saida<=~saida, cnt<=0, h_reg reloads.
  - Else: cnt<=cnt+1.
- While run=0: cnt, saida and h_reg hold.
- Timing after reset release with en=1:
  - First saida rise occurs at the h_reg-th clk edge.
  - Period is exactly 2*h_reg clk cycles.
  - With h_reg=1, saida toggles every clk (period 2).
- borda:
  - Registered. Equals 1 in exactly the cycle where saida has just become 1 (same edge that sets saida), else 0.
  - Never asserted during reset.
- Step mode, effective only when en=0, saida=0 and stepping=0:
  - step_q is the registered copy of step; a request is step & ~step_q.
  - A request sets stepping=1 and cnt=0.
  - The block then produces exactly one full period: saida high for h_reg cycles, then low for h_reg cycles.
  - stepping clears on the edge that completes the low phase (cnt==h_reg-1 while saida=0). saida then stays 0.
  - Requests during stepping, or while en=1, are ignored (not queued).
- en rising while stepping: the block continues free-running seamlessly (stepping clears at the end of the period).
- Counter wrap is impossible: cnt < h_reg <= 2^CNT_W-1. half_period of all-ones is legal.
- Asynchronous reset mid-phase: saida drops to 0 immediately (combinationally with rst), and borda drops to 0. The first post-reset rise follows the timing rule above.

Decomposition:
- Shared package clock_gerador_pkg: CNT_W default, and a function clamp_half(x) returning max(x,1).
- No sub-module needed; optionally an edge_detect sub-module for the step rising-edge detector.

Test Plan:
- Reset/default: rst high 3 cycles, en=1, half_period=0 -> saida=0 and borda=0 during reset; after release saida toggles every clk, period 2, and borda pulses every 2nd cycle.
- Divide by 6: half_period=3, en=1 -> saida high 3 clk, low 3 clk repeatedly; borda high 1 cycle per 6; first rise at the 3rd edge after reset.
- Mid-phase change: with period 6 running, set half_period=5 one cycle after a rising edge -> current high phase is still 3 cycles; following phases are 5 cycles each.
- Pause: drop en in the middle of a high phase with H=3 -> high phase completes (3 cycles), then saida stays 0 and borda stays 0 indefinitely.
- Single step: en=0, H=2, pulse step high for 4 cycles -> exactly one period (2 high, 2 low), one borda pulse, then idle. A second step asserted during that period produces nothing.
- Async reset while saida=1: assert rst between clk edges -> saida=0 before the next clk edge. After release with H=3, first rise is at the 3rd edge.
